// File: rtl/dadda_seq_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dadda_seq_mul_ctrl (with helper compressor_4_2)
//  Brief    : Iterative unsigned N x N multiplier. One 2N-bit 4:2 compressor
//             folds two partial products per cycle into a redundant
//             sum/carry pair. A final carry-propagate add then resolves the
//             pair. Valid/ready handshake on both sides.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  compressor_4_2 : four W-bit words in, two W-bit words out.
//  s1 + s2 == a1 + a2 + a3 + a4 (mod 2^W). s2 is already shifted to its
//  carry weight, so callers can add the two outputs directly.
// ----------------------------------------------------------------------------
module compressor_4_2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    input  logic [W-1:0] a3,
    input  logic [W-1:0] a4,
    output logic [W-1:0] s1,
    output logic [W-1:0] s2
);

    logic [W-1:0] w_x1;
    logic [W-1:0] w_maj1;
    logic [W-1:0] w_c1;
    logic [W-1:0] w_maj2;

    // First full-adder row reduces a1/a2/a3. The second row folds in a4.
    // Carries leaving the top bit have weight 2^W and are dropped.
    assign w_x1   = a1 ^ a2 ^ a3;
    assign w_maj1 = (a1 & a2) | (a1 & a3) | (a2 & a3);
    assign w_c1   = {w_maj1[W-2:0], 1'b0};
    assign s1     = w_x1 ^ w_c1 ^ a4;
    assign w_maj2 = (w_x1 & w_c1) | (w_x1 & a4) | (w_c1 & a4);
    assign s2     = {w_maj2[W-2:0], 1'b0};

endmodule

// ----------------------------------------------------------------------------
//  dadda_seq_mul_ctrl : top-level controller
// ----------------------------------------------------------------------------
module dadda_seq_mul_ctrl #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int c_PW = 2 * N;
    localparam int c_KW = (N / 2 > 1) ? $clog2(N / 2) : 1;
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(N / 2 - 1);
    localparam logic [c_KW-1:0] c_K_ONE  = c_KW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_FINAL  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_KW-1:0]   r_k;
    logic [N-1:0]      r_a;
    logic [N-1:0]      r_b;
    logic [c_PW-1:0]   r_acc_s;
    logic [c_PW-1:0]   r_acc_c;
    logic [c_PW-1:0]   r_product;
    logic              r_out_valid;
    logic              r_in_rdy;
    logic              r_busy;

    logic [c_KW:0]     w_idx_lo;
    logic [c_KW:0]     w_idx_hi;
    logic [c_PW-1:0]   w_a_ext;
    logic [c_PW-1:0]   w_pp_lo;
    logic [c_PW-1:0]   w_pp_hi;
    logic [c_PW-1:0]   w_s1;
    logic [c_PW-1:0]   w_s2;
    logic              w_accept;

    // Partial products 2k and 2k+1 for the current reduction step
    assign w_idx_lo = {r_k, 1'b0};
    assign w_idx_hi = {r_k, 1'b1};
    assign w_a_ext  = {{N{1'b0}}, r_a};
    assign w_pp_lo  = r_b[w_idx_lo] ? (w_a_ext << w_idx_lo) : '0;
    assign w_pp_hi  = r_b[w_idx_hi] ? (w_a_ext << w_idx_hi) : '0;

    compressor_4_2 #(
        .W (c_PW)
    ) u_cmp (
        .a1 (r_acc_s),
        .a2 (r_acc_c),
        .a3 (w_pp_lo),
        .a4 (w_pp_hi),
        .s1 (w_s1),
        .s2 (w_s2)
    );

    // A flush cycle never accepts operands, so in_ready is masked by flush
    assign in_ready  = r_in_rdy & ~flush;
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign busy      = r_busy;

    // Control FSM and datapath registers. Flush overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc_s     <= '0;
            r_acc_c     <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
            r_in_rdy    <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_in_rdy    <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_rdy <= 1'b1;
                    if (w_accept) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_acc_s  <= '0;
                        r_acc_c  <= '0;
                        r_k      <= '0;
                        r_state  <= S_REDUCE;
                        r_in_rdy <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_REDUCE: begin
                    r_acc_s <= w_s1;
                    r_acc_c <= w_s2;
                    r_k     <= r_k + c_K_ONE;
                    if (r_k == c_K_LAST) begin
                        r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    r_product   <= r_acc_s + r_acc_c;
                    r_out_valid <= 1'b1;
                    r_k         <= '0;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_rdy    <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
